// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared definitions for the fetch-stage program-counter generator:
//   RST_ENABLE  - level of the synchronous reset input that means "in reset"
//   pc_state_e  - 2-bit FSM state codes (RESET / START / RUN / HOLD)
//   align_mask  - mask that clears the low log2(step) bits of an address
// The address bus width is carried as the ADDR_W parameter of each user.
// -----------------------------------------------------------------------------
package pc_gen_pkg;

    // Reset is active-low
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        PC_ST_RESET = 2'd0,
        PC_ST_START = 2'd1,
        PC_ST_RUN   = 2'd2,
        PC_ST_HOLD  = 2'd3
    } pc_state_e;

    // step is a power of two, so step-1 is exactly the set of offset bits
    function automatic logic [63:0] align_mask(input int unsigned step);
        return ~(64'(step) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// -----------------------------------------------------------------------------
// pc_redirect_buf
// One-entry holding register for a redirect target that arrived while the
// fetch stage was stalled.
//   clk, rst      - clock, synchronous active-low reset
//   load          - capture load_target; while already valid this overwrites
//                   the held target (last redirect wins)
//   load_target   - aligned redirect address
//   consume       - the held target has been applied; drop it
//   clear         - discard any held target (newer redirect or trap)
//   valid, target - registered entry state
// Priority: clear > load > consume > hold.
// -----------------------------------------------------------------------------
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_target,
    input  logic              consume,
    input  logic              clear,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);

    logic              valid_q;
    logic              valid_d;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] target_d;

    // Next entry state from the clear/load/consume requests
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d  = 1'b1;
            target_d = load_target;
        end else if (consume) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid  = valid_q;
    assign target = target_q;

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Program-counter generator for the fetch stage. Produces the instruction
// address and the instruction-memory enable every cycle, with stall,
// branch/jump redirect and a one-entry buffer for redirects seen during stall.
//
// Optional feature macro: PC_TRAP_EN (adds trap input, epc output, TRAP_VEC).
//
// Parameters:
//   ADDR_W   - width of pc (>= 4)
//   STEP     - increment per fetched instruction, power of two 1..8
//   RESET_PC - pc value in reset and on the first fetch after release
//   TRAP_VEC - trap entry address (PC_TRAP_EN only)
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   stall         - hazard hold; pc frozen unless a redirect loads
//   fetch_ready   - memory accepts the address on pc this cycle
//   br_en         - redirect request pulse, br_target = destination
//   trap          - trap request pulse (PC_TRAP_EN only)
//   pc, ce        - registered fetch address and memory enable
//   pc_valid      - pc is a real fetch (0 for bubbles)
//   redirect_pend - a buffered redirect is waiting for the stall to clear
//   epc           - pc captured at the trap edge (PC_TRAP_EN only)
// -----------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        STEP     = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
`ifdef PC_TRAP_EN
    ,
    parameter logic [ADDR_W-1:0]  TRAP_VEC = ADDR_W'(32'h0000_0100)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              br_en,
    input  logic [ADDR_W-1:0] br_target,
`ifdef PC_TRAP_EN
    input  logic              trap,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pc_valid,
    output logic              redirect_pend
`ifdef PC_TRAP_EN
    ,
    output logic [ADDR_W-1:0] epc
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(STEP));
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

    pc_state_e         st_q;
    pc_state_e         st_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              ce_q;
    logic              ce_d;
    logic              pc_valid_q;
    logic              pc_valid_d;

    logic              adv;
    logic [ADDR_W-1:0] br_aligned;
    logic              trap_req;
    logic [ADDR_W-1:0] trap_pc;

    logic              buf_load;
    logic              buf_consume;
    logic              buf_clear;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    assign adv        = ce_q & fetch_ready & ~stall;
    assign br_aligned = br_target & ALIGN_MASK;

`ifdef PC_TRAP_EN
    assign trap_req = trap;
    assign trap_pc  = TRAP_VEC;
`else
    // Without the trap feature the trap path folds away
    assign trap_req = 1'b0;
    assign trap_pc  = RESET_PC;
`endif

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .load_target (br_aligned),
        .consume     (buf_consume),
        .clear       (buf_clear),
        .valid       (pend_valid),
        .target      (pend_target)
    );

    // Next state, next pc and buffer control: trap > br_en > pending > advance > hold
    always_comb begin
        st_d        = st_q;
        pc_d        = pc_q;
        ce_d        = ce_q;
        pc_valid_d  = pc_valid_q;
        buf_load    = 1'b0;
        buf_consume = 1'b0;
        buf_clear   = 1'b0;
        case (st_q)
            PC_ST_RESET: begin
                // First cycle out of reset presents RESET_PC as a real fetch
                st_d       = PC_ST_START;
                pc_d       = RESET_PC;
                ce_d       = 1'b1;
                pc_valid_d = 1'b1;
            end
            PC_ST_START, PC_ST_RUN, PC_ST_HOLD: begin
                ce_d = 1'b1;
                if (trap_req) begin
                    st_d       = PC_ST_RUN;
                    pc_d       = trap_pc;
                    pc_valid_d = 1'b0;
                    buf_clear  = 1'b1;
                end else if (br_en) begin
                    // Redirect loads at once even under stall. Under stall the
                    // target is also buffered so the fetch is re-issued when the
                    // hazard clears, since the stalled fetch is thrown away.
                    pc_d       = br_aligned;
                    pc_valid_d = 1'b0;
                    if (stall) begin
                        st_d     = PC_ST_HOLD;
                        buf_load = 1'b1;
                    end else begin
                        st_d      = PC_ST_RUN;
                        buf_clear = 1'b1;
                    end
                end else if (pend_valid && !stall) begin
                    st_d        = PC_ST_RUN;
                    pc_d        = pend_target;
                    pc_valid_d  = 1'b0;
                    buf_consume = 1'b1;
                end else if (adv) begin
                    // Modulo 2^ADDR_W: wraps silently
                    st_d       = PC_ST_RUN;
                    pc_d       = pc_q + STEP_INC;
                    pc_valid_d = 1'b1;
                end else begin
                    // Memory back-pressure keeps the fetch live; a stall makes it a bubble
                    pc_d       = pc_q;
                    pc_valid_d = ~stall;
                    st_d       = pend_valid ? PC_ST_HOLD : PC_ST_RUN;
                end
            end
            default: begin
                st_d       = PC_ST_RESET;
                pc_d       = RESET_PC;
                ce_d       = 1'b0;
                pc_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            st_q       <= PC_ST_RESET;
            pc_q       <= RESET_PC;
            ce_q       <= 1'b0;
            pc_valid_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            pc_valid_q <= pc_valid_d;
        end
    end

`ifdef PC_TRAP_EN
    logic [ADDR_W-1:0] epc_q;
    logic [ADDR_W-1:0] epc_d;

    // Capture the faulting fetch address on an accepted trap
    always_comb begin
        epc_d = epc_q;
        if (trap && (st_q != PC_ST_RESET)) begin
            epc_d = pc_q;
        end else begin
            epc_d = epc_q;
        end
    end

    // Exception pc register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end

    assign epc = epc_q;
`endif

    assign pc            = pc_q;
    assign ce            = ce_q;
    assign pc_valid      = pc_valid_q;
    assign redirect_pend = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
// Scoreboard bench for pc_gen. Each step drives inputs on the falling edge,
// pushes the hand-derived expected outputs, and compares them 1 time unit after
// the next rising edge. A second 8-bit instance free-runs to show wrap-around.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        fetch_ready;
    logic        br_en;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        ce;
    logic        pc_valid;
    logic        redirect_pend;
`ifdef PC_TRAP_EN
    logic        trap;
    logic [31:0] epc;
    logic [7:0]  sm_epc;
`endif

    logic [7:0]  sm_pc;
    logic        sm_ce;
    logic        sm_valid;
    logic        sm_pend;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        valid;
        logic        pend;
        logic [31:0] epc;
        logic [7:0]  sm_pc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          step_no = 0;
    logic [31:0] exp_epc = 32'h0;
    logic [7:0]  sm_exp  = 8'hF0;
    logic        sm_run  = 1'b0;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W   (32),
        .STEP     (4),
        .RESET_PC (32'h0000_1000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .fetch_ready   (fetch_ready),
        .br_en         (br_en),
        .br_target     (br_target),
`ifdef PC_TRAP_EN
        .trap          (trap),
`endif
        .pc            (pc),
        .ce            (ce),
        .pc_valid      (pc_valid),
        .redirect_pend (redirect_pend)
`ifdef PC_TRAP_EN
        ,
        .epc           (epc)
`endif
    );

    pc_gen #(
        .ADDR_W   (8),
        .STEP     (4),
        .RESET_PC (8'hF0)
    ) dut_small (
        .clk           (clk),
        .rst           (rst),
        .stall         (1'b0),
        .fetch_ready   (1'b1),
        .br_en         (1'b0),
        .br_target     (8'h00),
`ifdef PC_TRAP_EN
        .trap          (1'b0),
`endif
        .pc            (sm_pc),
        .ce            (sm_ce),
        .pc_valid      (sm_valid),
        .redirect_pend (sm_pend)
`ifdef PC_TRAP_EN
        ,
        .epc           (sm_epc)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic fr, input logic b,
                        input logic [31:0] tgt, input logic [31:0] e_pc,
                        input logic e_ce, input logic e_v, input logic e_p);
        exp_t e;
        @(negedge clk);
        rst         = r;
        stall       = s;
        fetch_ready = fr;
        br_en       = b;
        br_target   = tgt;
        // 8-bit instance: RESET_PC in reset and on the release edge, then +4
        if (!r) begin
            sm_exp = 8'hF0;
            sm_run = 1'b0;
        end else if (!sm_run) begin
            sm_exp = 8'hF0;
            sm_run = 1'b1;
        end else begin
            sm_exp = sm_exp + 8'd4;
        end
        e.pc    = e_pc;
        e.ce    = e_ce;
        e.valid = e_v;
        e.pend  = e_p;
        e.epc   = exp_epc;
        e.sm_pc = sm_exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        if (sb.size() == 0) begin
            check_eq($sformatf("s%0d.sb_empty", step_no), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq($sformatf("s%0d.pc", step_no), pc, e.pc);
            check_eq($sformatf("s%0d.ce", step_no), 32'(ce), 32'(e.ce));
            check_eq($sformatf("s%0d.pc_valid", step_no), 32'(pc_valid), 32'(e.valid));
            check_eq($sformatf("s%0d.redirect_pend", step_no), 32'(redirect_pend), 32'(e.pend));
            check_eq($sformatf("s%0d.sm_pc", step_no), 32'(sm_pc), 32'(e.sm_pc));
`ifdef PC_TRAP_EN
            check_eq($sformatf("s%0d.epc", step_no), epc, e.epc);
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        fetch_ready = 1'b1;
        br_en       = 1'b0;
        br_target   = 32'h0;
`ifdef PC_TRAP_EN
        trap        = 1'b0;
`endif
        //   rst   stall fr    br    target         pc             ce    valid pend
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_1000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_1000, 1'b0, 1'b0, 1'b0);
        // Release: RESET_PC for one full cycle, then increments
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_1000, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_1004, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_1008, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_100C, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_1010, 1'b1, 1'b1, 1'b0);
        // fetch_ready low: pc holds, fetch stays valid
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_1010, 1'b1, 1'b1, 1'b0);
`ifdef PC_TRAP_EN
        // Trap beats a simultaneous branch; epc gets the pc at that edge
        trap    = 1'b1;
        exp_epc = 32'h0000_1010;
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
        trap    = 1'b0;
`endif
        // Branch: target aligned, bubble on the load cycle
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_2003, 32'h0000_2000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_2004, 1'b1, 1'b1, 1'b0);
        // Three stalled cycles, two redirects inside; last one wins
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_2004, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_3000, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_4000, 1'b1, 1'b0, 1'b1);
        // First unstalled edge re-applies the buffered target, pend clears
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_4000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_4004, 1'b1, 1'b1, 1'b0);
        // New branch in the same cycle as a pending one: new branch wins, pend clears
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_5000, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_6008, 32'h0000_6008, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_600C, 1'b1, 1'b1, 1'b0);
        // 32-bit wrap: aligned top address plus STEP gives zero
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1'b1, 1'b0);
        // Stall with memory not ready: hold as a bubble
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b0);
        // Reset while holding a pending redirect drops it
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_7000, 32'h0000_7000, 1'b1, 1'b0, 1'b1);
        exp_epc = 32'h0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_1000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_1000, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_1004, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
